// File: rtl/imem_boot_loader.sv
// Boot/reload sequencer: streams a host program into instruction RAM while holding
// the core in reset, then releases it after a settle delay.
module imem_boot_loader #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RUN_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              trunc_err,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned DLY_W = (RUN_DELAY > 1) ? $clog2(RUN_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RUN_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [DLY_W-1:0]  dly_cnt;
    logic              accept;
    logic              at_end;
    logic              exit_load;
    logic              start_ok;

    always_comb begin
        // host_ready is the registered image of "state is LOAD"
        accept     = host_ready & host_valid;
        at_end     = (ptr == '1);
        exit_load  = accept & (host_last | at_end);
        start_ok   = start & ((state == IDLE) | (state == RUN));
        state_next = state;
        unique case (state)
            IDLE:    if (start_ok) state_next = LOAD;
            LOAD:    if (exit_load) state_next = FLUSH;
            FLUSH:   if (dly_cnt == DLY_LAST) state_next = RUN;
            RUN:     if (start_ok) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            host_ready <= 1'b0;
            busy       <= 1'b0;
            core_rst   <= 1'b1;
        end else begin
            state      <= state_next;
            host_ready <= (state_next == LOAD);
            busy       <= (state_next == LOAD) | (state_next == FLUSH);
            core_rst   <= (state_next != RUN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            ptr        <= '0;
            word_count <= '0;
            trunc_err  <= 1'b0;
            dly_cnt    <= '0;
        end else begin
            imem_we <= accept;
            if (accept) begin
                imem_addr  <= ptr;
                imem_wdata <= host_data;
            end

            if (start_ok) begin
                ptr        <= '0;
                word_count <= '0;
                trunc_err  <= 1'b0;
            end else if (accept) begin
                // ptr parks at the last address; the full-depth exit ends the load there
                if (!at_end) ptr <= ptr + ADDR_W'(1);
                word_count <= word_count + (ADDR_W + 1)'(1);
                if (at_end && !host_last) trunc_err <= 1'b1;
            end

            // first FLUSH cycle coincides with the final RAM write
            if (state == FLUSH) dly_cnt <= dly_cnt + DLY_W'(1);
            else                dly_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: randomized host traffic against a
// transaction-level reference model, plus literal pins on directed scenarios.
`timescale 1ns/1ps
module tb_imem_boot_loader;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int RUN_DELAY = 2;
    localparam int DEPTH     = 32;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_FLUSH = 2;
    localparam int P_RUN   = 3;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              start      = 1'b0;
    logic              host_valid = 1'b0;
    logic [DATA_W-1:0] host_data  = '0;
    logic              host_last  = 1'b0;
    logic              host_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              trunc_err;
    logic [ADDR_W:0]   word_count;

    imem_boot_loader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RUN_DELAY(RUN_DELAY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .host_valid(host_valid),
        .host_data (host_data),
        .host_last (host_last),
        .host_ready(host_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .busy      (busy),
        .trunc_err (trunc_err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    logic [DATA_W-1:0] shadow[DEPTH];
    logic [DATA_W-1:0] prog[64];

    // reference model: phase plus counters, stepped once per clock from the inputs
    int          m_phase = P_IDLE;
    int          m_ptr   = 0;
    int          m_count = 0;
    int          m_left  = 0;
    bit          m_trunc = 1'b0;
    bit          m_we    = 1'b0;
    int          m_addr  = 0;
    logic [31:0] m_data  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin : model
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_phase = P_IDLE; m_ptr = 0; m_count = 0; m_left = 0;
                m_trunc = 0; m_we = 0; m_addr = 0; m_data = '0;
            end else begin
                m_we = 0;
                case (m_phase)
                    P_IDLE, P_RUN: if (start) begin
                        m_phase = P_LOAD; m_ptr = 0; m_count = 0; m_trunc = 0;
                    end
                    P_LOAD: if (host_valid) begin
                        m_we = 1; m_addr = m_ptr; m_data = host_data;
                        m_count++;
                        if (host_last || m_ptr == DEPTH - 1) begin
                            if (!host_last) m_trunc = 1;
                            m_phase = P_FLUSH;
                            m_left  = RUN_DELAY;
                        end
                        m_ptr++;
                    end
                    P_FLUSH: begin
                        m_left--;
                        if (m_left == 0) m_phase = P_RUN;
                    end
                    default: m_phase = P_IDLE;
                endcase
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("host_ready", host_ready, m_phase == P_LOAD);
                chk("busy", busy, m_phase == P_LOAD || m_phase == P_FLUSH);
                chk("core_rst", core_rst, m_phase != P_RUN);
                chk("imem_we", imem_we, m_we);
                chk("imem_addr", imem_addr, m_addr);
                chk("imem_wdata", imem_wdata, m_data);
                chk("word_count", word_count, m_count);
                chk("trunc_err", trunc_err, m_trunc);
            end
        end
    end

    initial begin : ram_capture
        forever begin
            @(posedge clk);
            if (imem_we === 1'b1) shadow[imem_addr] = imem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: valid every cycle, 1: valid toggling, 2: random valid with stray starts
    task automatic load(input int n, input bit with_last, input int mode, input int abort_at,
                        output int accepted);
        int idx    = 0;
        int budget = 0;
        bit rdy;
        bit tog    = 1'b1;
        pulse_start();
        chk("start_core_rst", core_rst, 1);
        chk("start_ready", host_ready, 1);
        while (idx < n && idx < DEPTH && budget < 400) begin
            case (mode)
                0:       host_valid = 1'b1;
                1:       begin host_valid = tog; tog = !tog; end
                default: host_valid = 1'($urandom_range(0, 1));
            endcase
            start     = (mode == 2) && (idx == 1 || $urandom_range(0, 7) == 0);
            host_data = prog[idx];
            host_last = with_last && (idx == n - 1);
            @(negedge clk);
            rdy = host_ready;
            @(posedge clk);
            if (host_valid && rdy) idx++;
            budget++;
            if (abort_at != 0 && idx == abort_at) begin
                #3;
                rst = 1'b0;
                #1;
                chk("abort_imem_we", imem_we, 0);
                chk("abort_core_rst", core_rst, 1);
                chk("abort_ready", host_ready, 0);
                break;
            end
            #2;
        end
        start = 1'b0; host_valid = 1'b0; host_last = 1'b0;
        chk("load_timeout", budget >= 400, 0);
        accepted = idx;
    endtask

    task automatic wait_run();
        int b = 0;
        while (core_rst !== 1'b0 && b < 50) begin
            tick();
            b++;
        end
        chk("release_timeout", b < 50, 1);
    endtask

    task automatic check_ram(input int n);
        for (int i = 0; i < n; i++) chk($sformatf("ram[%0d]", i), shadow[i], prog[i]);
    endtask

    task automatic fill_prog();
        for (int i = 0; i < 64; i++) prog[i] = $urandom;
    endtask

    initial begin : stim
        int acc;
        int n;
        bit wl;

        // reset held with random inputs
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom_range(0, 1));
            host_valid = 1'($urandom_range(0, 1));
            host_data = $urandom;
            host_last = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_core_rst", core_rst, 1);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_ready", host_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_word_count", word_count, 0);
        start = 0; host_valid = 0; host_last = 0;
        rst = 1'b1;
        tick(); tick();
        chk("idle_core_rst", core_rst, 1);

        // four-word program, valid every cycle
        prog[0] = 32'h00500093; prog[1] = 32'h00A00113;
        prog[2] = 32'h002081B3; prog[3] = 32'h00000013;
        load(4, 1, 0, 0, acc);
        chk("p4_last_we", imem_we, 1);
        chk("p4_last_addr", imem_addr, 3);
        chk("p4_last_data", imem_wdata, 32'h00000013);
        chk("p4_hold1", core_rst, 1);
        tick();
        chk("p4_hold2", core_rst, 1);
        chk("p4_we_off", imem_we, 0);
        tick();
        chk("p4_release", core_rst, 0);
        chk("p4_count", word_count, 4);
        chk("p4_trunc", trunc_err, 0);
        check_ram(4);
        repeat (3) tick();

        // bursty host
        fill_prog();
        load(7, 1, 1, 0, acc);
        wait_run();
        chk("burst_count", word_count, 7);
        check_ram(7);

        // overflow: no last marker
        fill_prog();
        load(40, 0, 0, 0, acc);
        chk("ovf_accepted", acc, 32);
        host_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_data = prog[32 + i];
            tick();
        end
        host_valid = 1'b0;
        wait_run();
        chk("ovf_count", word_count, 32);
        chk("ovf_trunc", trunc_err, 1);
        check_ram(32);

        // reload two words; truncation flag clears
        fill_prog();
        load(2, 1, 0, 0, acc);
        chk("reload_trunc_clr", trunc_err, 0);
        wait_run();
        chk("reload_count", word_count, 2);
        check_ram(2);

        // exactly full depth with last on the final word is not a truncation
        fill_prog();
        load(32, 1, 0, 0, acc);
        wait_run();
        chk("full_count", word_count, 32);
        chk("full_trunc", trunc_err, 0);
        check_ram(32);

        // stray start during load, then async reset after 3rd accept
        fill_prog();
        load(8, 1, 2, 3, acc);
        tick(); tick();
        chk("abort_idle_core_rst", core_rst, 1);
        rst = 1'b1;
        tick();
        fill_prog();
        load(3, 1, 0, 0, acc);
        wait_run();
        chk("restart_count", word_count, 3);
        check_ram(3);

        // randomized loads
        for (int k = 0; k < 6; k++) begin
            fill_prog();
            n  = $urandom_range(1, 36);
            wl = (n <= DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            load(n, wl, 2, 0, acc);
            wait_run();
            check_ram((n < DEPTH) ? n : DEPTH);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
